// File: rtl/inst_queue_way0_pkg.sv
// inst_queue_way0_pkg: shared widths, NOP encoding and queue entry type for the way0 instruction queue
package inst_queue_way0_pkg;
  localparam int INST_W = 32;
  localparam int ADDR_PC_W = 32;
  localparam logic [INST_W-1:0] INST_NOP = 32'h00000013;
  typedef struct packed {
    logic [ADDR_PC_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } inst_entry_t;
endpackage

// File: rtl/inst_queue_mem.sv
// inst_queue_mem: DEPTH x 64 entry array, one write port, one asynchronous read port, no reset
// Ports: clk; we/waddr/wdata write port; raddr/rdata combinational read port.
module inst_queue_mem
  import inst_queue_way0_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  inst_entry_t       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output inst_entry_t       rdata
);
  inst_entry_t mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/inst_queue_way0.sv
// inst_queue_way0: in-order {pc, inst} FIFO between way0 fetch and way0 decode, flushed on redirect
// Ports: clk, rst (async, active-high); flush_i empties the queue and blocks this cycle's push;
//   fetchValid_i/fetchInst_i/fetchAddr_i/fetchReady_o push side;
//   decValid_o/decInst_o/decAddr_o/decReady_i pop side (NOP and 0 when nothing valid);
//   count_o occupancy 0..DEPTH.
// Define INST_QUEUE_BYPASS_EN to forward fetch straight to decode when the queue is empty.
module inst_queue_way0
  import inst_queue_way0_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 fetchValid_i,
  input  logic [INST_W-1:0]    fetchInst_i,
  input  logic [ADDR_PC_W-1:0] fetchAddr_i,
  output logic                 fetchReady_o,
  output logic                 decValid_o,
  output logic [INST_W-1:0]    decInst_o,
  output logic [ADDR_PC_W-1:0] decAddr_o,
  input  logic                 decReady_i,
  output logic [ADDR_W:0]      count_o
);
  localparam logic [ADDR_W:0] cnt_full = (ADDR_W+1)'(DEPTH);
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0] count;
  logic empty, byp, byp_take, push, pop, do_push, do_pop;
  inst_entry_t head, wr_entry;
  assign empty = count == '0;
  assign fetchReady_o = count != cnt_full;
`ifdef INST_QUEUE_BYPASS_EN
  assign byp = empty & fetchValid_i & ~flush_i;
`else
  assign byp = 1'b0;
`endif
  assign decValid_o = ~empty | byp;
  assign decInst_o = ~empty ? head.inst : byp ? fetchInst_i : INST_NOP;
  assign decAddr_o = ~empty ? head.pc : byp ? fetchAddr_i : '0;
  assign push = fetchValid_i & fetchReady_o & ~flush_i;
  assign pop = decValid_o & decReady_i & ~flush_i;
  // A forwarded instruction taken by decode never touches storage or pointers.
  assign byp_take = byp & decReady_i;
  assign do_push = push & ~byp_take;
  assign do_pop = pop & ~byp_take;
  assign wr_entry = '{pc: fetchAddr_i, inst: fetchInst_i};
  assign count_o = count;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= (do_push & ~do_pop) ? count + 1'b1 : (do_pop & ~do_push) ? count - 1'b1 : count;
    end
  inst_queue_mem #(.DEPTH(DEPTH)) u_mem (
    .clk  (clk),
    .we   (do_push),
    .waddr(wr_ptr),
    .wdata(wr_entry),
    .raddr(rd_ptr),
    .rdata(head)
  );
endmodule

// File: tb/tb_inst_queue_way0.sv
// tb_inst_queue_way0: directed and random stimulus against a queue-based reference model of inst_queue_way0
module tb_inst_queue_way0;
  localparam int DEPTH = 4;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, fv = 1'b0, dr = 1'b0;
  logic [31:0] f_inst = '0, f_addr = '0;
  logic f_ready, d_valid;
  logic [31:0] d_inst, d_addr;
  logic [2:0] count;
  int checks = 0, errors = 0;
  logic [63:0] q[$];
  inst_queue_way0 #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush_i(flush),
    .fetchValid_i(fv), .fetchInst_i(f_inst), .fetchAddr_i(f_addr), .fetchReady_o(f_ready),
    .decValid_o(d_valid), .decInst_o(d_inst), .decAddr_o(d_addr), .decReady_i(dr),
    .count_o(count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic bit bypass_on();
`ifdef INST_QUEUE_BYPASS_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction
  // Starts at posedge+1: drives inputs, checks outputs against the model, advances one clock.
  task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] i, input logic r, input logic f);
    bit byp, exp_valid, exp_ready;
    logic [31:0] exp_inst, exp_addr;
    fv = v; f_addr = a; f_inst = i; dr = r; flush = f;
    #1;
    byp = bypass_on() && q.size() == 0 && v && !f;
    exp_ready = q.size() != DEPTH;
    exp_valid = q.size() != 0 || byp;
    exp_addr = q.size() != 0 ? q[0][63:32] : byp ? a : 32'h0;
    exp_inst = q.size() != 0 ? q[0][31:0] : byp ? i : 32'h00000013;
    chk("ready", 64'(f_ready), 64'(exp_ready));
    chk("valid", 64'(d_valid), 64'(exp_valid));
    chk("inst", 64'(d_inst), 64'(exp_inst));
    chk("addr", 64'(d_addr), 64'(exp_addr));
    chk("count", 64'(count), 64'(q.size()));
    @(posedge clk);
    if (f) q.delete();
    else if (byp && r) begin end
    else begin
      if (exp_valid && r) void'(q.pop_front());
      if (v && exp_ready) q.push_back({a, i});
    end
    #1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 10; k++) cycle(0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) cycle(1, 32'h80000000 + 32'(4 * k), 32'h1000 + 32'(k), 0, 0);
    chk("full_count", 64'(count), 64'd4);
    for (int k = 0; k < 4; k++) cycle(0, 0, 0, 1, 0);
    for (int k = 0; k < 4; k++) cycle(1, 32'h90000000 + 32'(4 * k), 32'h2000 + 32'(k), 0, 0);
    cycle(1, 32'h90000010, 32'h2004, 1, 0);
    chk("after_full_pop", 64'({f_ready, count}), 64'({1'b1, 3'd3}));
    for (int k = 0; k < 20; k++) cycle(1, 32'hA0000000 + 32'(4 * k), 32'h3000 + 32'(k), 1, 0);
    while (q.size() > 3) cycle(0, 0, 0, 1, 0);
    chk("pre_flush_count", 64'(count), 64'd3);
    cycle(1, 32'hDEAD0000, 32'hDEAD, 0, 1);
    chk("flush_empty", 64'({d_valid, count}), 64'({1'b0, 3'd0}));
    cycle(0, 0, 0, 1, 0);
    cycle(1, 32'hB0000000, 32'h4000, 0, 0);
    cycle(1, 32'hB0000004, 32'h4001, 0, 0);
    #2 rst = 1'b1;
    #1;
    q.delete();
    chk("async_rst", {29'h0, count, f_ready, d_valid, d_inst}, {29'h0, 3'd0, 1'b1, 1'b0, 32'h00000013});
    chk("async_rst_addr", 64'(d_addr), 64'h0);
    @(posedge clk);
    #1 rst = 1'b0;
`ifdef INST_QUEUE_BYPASS_EN
    fv = 1'b1; f_inst = 32'h00100093; f_addr = 32'hC0000000; dr = 1'b1; flush = 1'b0;
    #1;
    chk("bypass_same_cycle", {31'h0, d_valid, d_inst}, {31'h0, 1'b1, 32'h00100093});
    cycle(1, 32'hC0000000, 32'h00100093, 1, 0);
    chk("bypass_count", 64'(count), 64'd0);
`endif
    for (int k = 0; k < 400; k++)
      cycle($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule
